// File: rtl/counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank_if
// Description : Single-cycle register bus between a host and counter_bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_bank_if;
    logic        valid;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output valid, we, sel, adr, wdata, input  rdata, ack);
    modport slave  (input  valid, we, sel, adr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank
// Description : Bank of CHANNELS prescaled up/down counters with compare match,
//               sticky status and interrupts. Define COUNTER_BANK_LA_EN to add
//               the la_load/la_value direct-load ports.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_bank #(
    parameter int BITS     = 32,
    parameter int CHANNELS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    counter_bank_if.slave            bus,
    output logic [CHANNELS*BITS-1:0] count_o,
    output logic [CHANNELS-1:0]      irq
`ifdef COUNTER_BANK_LA_EN
    ,
    input  logic [CHANNELS-1:0]      la_load,
    input  logic [BITS-1:0]          la_value
`endif
);

    localparam logic [1:0]      c_REG_COUNT   = 2'd0;
    localparam logic [1:0]      c_REG_CTRL    = 2'd1;
    localparam logic [1:0]      c_REG_COMPARE = 2'd2;
    localparam logic [1:0]      c_REG_STATUS  = 2'd3;
    localparam logic [BITS-1:0] c_ONE         = BITS'(1);

    logic        r_ack;
    logic [31:0] r_rdata;
    logic        w_access;
    logic        w_wr;
    logic [3:0]  w_ch;
    logic [1:0]  w_reg;
    logic [31:0] w_rd_data;
    logic        w_unused;

    logic [31:0] w_rd_count   [CHANNELS];
    logic [31:0] w_rd_ctrl    [CHANNELS];
    logic [31:0] w_rd_compare [CHANNELS];
    logic [31:0] w_rd_status  [CHANNELS];

    // Byte-lane merge of bus write data over a register's current value.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] wd,
                                            input logic [3:0]  be);
        logic [31:0] v;
        v = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        end
        return v;
    endfunction

    assign w_access = bus.valid && !r_ack;
    assign w_wr     = w_access && bus.we;
    assign w_ch     = bus.adr[7:4];
    assign w_reg    = bus.adr[3:2];
    assign w_unused = ^{bus.adr[31:8], bus.adr[1:0]};

    // Channels at or beyond CHANNELS never match here, so they read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_ch == 4'(k)) begin
                case (w_reg)
                    c_REG_COUNT:   w_rd_data = w_rd_count[k];
                    c_REG_CTRL:    w_rd_data = w_rd_ctrl[k];
                    c_REG_COMPARE: w_rd_data = w_rd_compare[k];
                    c_REG_STATUS:  w_rd_data = w_rd_status[k];
                    default:       w_rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access && !bus.we) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign bus.ack   = r_ack;
    assign bus.rdata = r_rdata;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [BITS-1:0] r_count;
        logic [BITS-1:0] r_compare;
        logic            r_en;
        logic            r_dir;
        logic            r_auto;
        logic            r_irq_en;
        logic [7:0]      r_prescale;
        logic [7:0]      r_presc_cnt;
        logic            r_match;

        logic            w_sel_ch;
        logic            w_count_wr;
        logic            w_ctrl_wr;
        logic            w_cmp_wr;
        logic            w_clr;
        logic            w_tick;
        logic            w_match_set;
        logic [BITS-1:0] w_tick_val;
        logic [BITS-1:0] w_count_next;
        logic [31:0]     w_cnt_m;
        logic [31:0]     w_cmp_m;
        logic            w_unused_hi;

        assign w_sel_ch    = w_wr && (w_ch == 4'(i));
        assign w_count_wr  = w_sel_ch && (w_reg == c_REG_COUNT);
        assign w_ctrl_wr   = w_sel_ch && (w_reg == c_REG_CTRL);
        assign w_cmp_wr    = w_sel_ch && (w_reg == c_REG_COMPARE);
        assign w_clr       = w_sel_ch && (w_reg == c_REG_STATUS) && bus.sel[0] && bus.wdata[0];
        assign w_cnt_m     = f_merge(32'(r_count), bus.wdata, bus.sel);
        assign w_cmp_m     = f_merge(32'(r_compare), bus.wdata, bus.sel);
        assign w_unused_hi = ^{w_cnt_m, w_cmp_m};
        assign w_tick      = r_en && (r_presc_cnt == r_prescale);

        always_comb begin
            w_tick_val  = r_count;
            w_match_set = 1'b0;
            if (!r_dir) begin
                if (r_count == r_compare) begin
                    w_match_set = w_tick;
                    w_tick_val  = r_auto ? '0 : r_count + c_ONE;
                end else begin
                    w_tick_val  = r_count + c_ONE;
                end
            end else begin
                if (r_count == '0) begin
                    w_match_set = w_tick;
                    w_tick_val  = r_auto ? r_compare : '1;
                end else begin
                    w_tick_val  = r_count - c_ONE;
                end
            end
        end

        // COUNT source priority: direct load, then bus write, then tick.
        always_comb begin
            w_count_next = r_count;
            if (w_count_wr) begin
                w_count_next = w_cnt_m[BITS-1:0];
            end else if (w_tick) begin
                w_count_next = w_tick_val;
            end
`ifdef COUNTER_BANK_LA_EN
            if (la_load[i]) begin
                w_count_next = la_value;
            end
`endif
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_count     <= '0;
                r_compare   <= '1;
                r_en        <= 1'b0;
                r_dir       <= 1'b0;
                r_auto      <= 1'b0;
                r_irq_en    <= 1'b0;
                r_prescale  <= '0;
                r_presc_cnt <= '0;
                r_match     <= 1'b0;
            end else begin
                r_count <= w_count_next;
                if (w_ctrl_wr) begin
                    if (bus.sel[0]) begin
                        {r_irq_en, r_auto, r_dir, r_en} <= bus.wdata[3:0];
                    end
                    if (bus.sel[1]) begin
                        r_prescale <= bus.wdata[15:8];
                    end
                    r_presc_cnt <= '0;
                end else if (r_en) begin
                    r_presc_cnt <= w_tick ? 8'd0 : r_presc_cnt + 8'd1;
                end
                if (w_cmp_wr) begin
                    r_compare <= w_cmp_m[BITS-1:0];
                end
                // A fresh match outranks a coincident write-1-to-clear.
                r_match <= (r_match && !w_clr) || w_match_set;
            end
        end

        assign count_o[i*BITS +: BITS] = r_count;
        assign irq[i]                  = r_match && r_irq_en;
        assign w_rd_count[i]           = 32'(r_count);
        assign w_rd_compare[i]         = 32'(r_compare);
        assign w_rd_ctrl[i]            = {16'h0000, r_prescale, 4'h0, r_irq_en, r_auto, r_dir, r_en};
        assign w_rd_status[i]          = {31'd0, r_match};
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_bank
// Description : Directed bench for counter_bank (32-bit and 8-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bank;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_bank_if if0();
    counter_bank_if if1();

    logic [4*32-1:0] count0;
    logic [3:0]      irq0;
    logic [4*8-1:0]  count1;
    logic [3:0]      irq1;
`ifdef COUNTER_BANK_LA_EN
    logic [3:0]      la_load0;
    logic [31:0]     la_value0;
    logic [3:0]      la_load1;
    logic [7:0]      la_value1;
`endif

    counter_bank #(.BITS(32), .CHANNELS(4)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .bus      (if0),
        .count_o  (count0),
        .irq      (irq0)
`ifdef COUNTER_BANK_LA_EN
        ,
        .la_load  (la_load0),
        .la_value (la_value0)
`endif
    );

    counter_bank #(.BITS(8), .CHANNELS(4)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .bus      (if1),
        .count_o  (count1),
        .irq      (irq1)
`ifdef COUNTER_BANK_LA_EN
        ,
        .la_load  (la_load1),
        .la_value (la_value1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
        if (d == 0) begin
            if0.valid = v; if0.we = w; if0.adr = a; if0.wdata = wd; if0.sel = s;
        end else begin
            if1.valid = v; if1.we = w; if1.adr = a; if1.wdata = wd; if1.sel = s;
        end
    endtask

    function automatic logic ack_of(input int d);
        return (d == 0) ? if0.ack : if1.ack;
    endfunction

    function automatic logic [31:0] rdata_of(input int d);
        return (d == 0) ? if0.rdata : if1.rdata;
    endfunction

    // Returns on the negedge right after the acknowledging edge.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd);
        @(negedge clk);
        check("ack_idle", 32'(ack_of(d)), 32'd0);
        drive(d, 1'b1, w, a, wd, s);
        @(negedge clk);
        check("ack_pulse", 32'(ack_of(d)), 32'd1);
        rd = rdata_of(d);
        drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(d, 1'b1, a, wd, s, dummy);
    endtask

    task automatic rd_check(input int d, input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        xfer(d, 1'b0, a, 32'd0, 4'hF, r);
        check(tag, r, exp);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
`ifdef COUNTER_BANK_LA_EN
        la_load0 = '0; la_value0 = '0; la_load1 = '0; la_value1 = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ack",    32'(if0.ack), 32'd0);
        check("rst_rdata",  if0.rdata, 32'd0);
        check("rst_irq",    32'(irq0), 32'd0);
        check("rst_count0", 32'(|count0), 32'd0);
        check("rst_count1", 32'(|count1), 32'd0);
        reset = 1'b0;

        // Reset values of channel 0 registers
        rd_check(0, 32'h00, 32'h0000_0000, "ch0_count");
        rd_check(0, 32'h04, 32'h0000_0000, "ch0_ctrl");
        rd_check(0, 32'h08, 32'hFFFF_FFFF, "ch0_compare");
        rd_check(0, 32'h0C, 32'h0000_0000, "ch0_status");
        rd_check(1, 32'h08, 32'h0000_00FF, "b8_compare_rst");

        // ch1: up, autoreload at 5, irq enabled
        wr(0, 32'h18, 32'd5, 4'hF);
        wr(0, 32'h14, 32'h0000_000D, 4'hF);
        check("ch1_cnt_start", count0[32 +: 32], 32'd0);
        repeat (5) @(negedge clk);
        check("ch1_cnt_5", count0[32 +: 32], 32'd5);
        check("ch1_irq_pre", 32'(irq0[1]), 32'd0);
        @(negedge clk);
        check("ch1_cnt_wrap", count0[32 +: 32], 32'd0);
        check("ch1_irq_set", 32'(irq0[1]), 32'd1);
        wr(0, 32'h1C, 32'd1, 4'h1);
        check("ch1_irq_clr", 32'(irq0[1]), 32'd0);
        rd_check(0, 32'h1C, 32'd0, "ch1_status_clr");

        // ch2: down, prescale 3, starting at 0
        wr(0, 32'h20, 32'd0, 4'hF);
        wr(0, 32'h24, 32'h0000_0303, 4'hF);
        check("ch2_cnt_start", count0[64 +: 32], 32'd0);
        repeat (3) @(negedge clk);
        check("ch2_cnt_hold", count0[64 +: 32], 32'd0);
        @(negedge clk);
        check("ch2_cnt_wrap", count0[64 +: 32], 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        check("ch2_cnt_dec", count0[64 +: 32], 32'hFFFF_FFFE);
        rd_check(0, 32'h2C, 32'd1, "ch2_status");
        check("ch2_irq_off", 32'(irq0[2]), 32'd0);

        // Bus COUNT write beats a tick on the same edge
        wr(0, 32'h10, 32'h0000_0100, 4'hF);
        check("ch1_wr_wins", count0[32 +: 32], 32'h0000_0100);

        // ch3: match every cycle, clear coincident with a new match
        wr(0, 32'h38, 32'd0, 4'hF);
        wr(0, 32'h34, 32'h0000_000D, 4'hF);
        wr(0, 32'h3C, 32'd1, 4'h1);
        check("ch3_match_kept", 32'(irq0[3]), 32'd1);
        check("ch3_cnt_reload", count0[96 +: 32], 32'd0);

        // Byte lanes, undefined CTRL bits, out-of-range channel
        wr(0, 32'h00, 32'hAABB_CCDD, 4'b0101);
        rd_check(0, 32'h00, 32'h00BB_00DD, "ch0_byte_lanes");
        wr(0, 32'h04, 32'hFFFF_FFF0, 4'hF);
        rd_check(0, 32'h04, 32'h0000_FF00, "ch0_ctrl_undef");
        rd_check(0, 32'hF0, 32'd0, "oor_read");
        wr(0, 32'hF0, 32'h1234_5678, 4'hF);
        rd_check(0, 32'h00, 32'h00BB_00DD, "oor_write_ignored");

        // 8-bit instance
        wr(1, 32'h00, 32'h0000_01FF, 4'b0011);
        rd_check(1, 32'h00, 32'h0000_00FF, "b8_count_trunc");
        rd_check(1, 32'hF0, 32'd0, "b8_oor_read");

`ifdef COUNTER_BANK_LA_EN
        la_load0  = 4'b0001;
        la_value0 = 32'h55;
        wr(0, 32'h00, 32'h11, 4'hF);
        la_load0  = 4'b0000;
        rd_check(0, 32'h00, 32'h0000_0055, "la_priority");
`endif

        // Reset arriving with a pending access drops it
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h08, 32'd0, 4'hF);
        @(negedge clk);
        check("rst_drop_ack", 32'(if0.ack), 32'd0);
        check("rst_drop_cnt", 32'(|count0), 32'd0);
        check("rst_drop_irq", 32'(irq0), 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_drop_idle", 32'(if0.ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
